conv_layer_output_serializer: RTL and testbench

Row-to-stream transmitter on the output side of the convolution layer: accepts complete result rows as one wide parallel word, queues them in a small row FIFO, and emits them one data word per cycle over a valid/ready stream. It sits between the convolution kernel array and the pooling or memory writer. It reverses the input buffer's word-serial to row-parallel direction and uses the same packing: column 0 occupies the most-significant word of a row.

---
 rtl/conv_layer_output_serializer.sv | 130 +++++++++++++
 tb/tb_conv_layer_output_serializer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : conv_layer_output_serializer
// Description : Row-to-stream transmitter for the convolution layer output.
//               Queues complete result rows in a small row FIFO and emits
//               them one word per cycle over a valid/ready stream, column 0
//               (most-significant word of the row) first.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_layer_output_serializer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ROW_WORDS      = 6,
    parameter int ROWS_PER_FRAME = 6,
    parameter int ROW_DEPTH      = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic [ROW_WORDS*DATA_WIDTH-1:0]   row_in,
    input  logic                              row_valid,
    output logic                              row_ready,
    output logic [DATA_WIDTH-1:0]             data_out,
    output logic                              data_valid,
    input  logic                              data_ready,
    output logic [$clog2(ROW_WORDS)-1:0]      col_index,
    output logic [$clog2(ROWS_PER_FRAME)-1:0] row_index,
    output logic                              last
);

    localparam int c_row_w  = ROW_WORDS * DATA_WIDTH;
    localparam int c_col_w  = $clog2(ROW_WORDS);
    localparam int c_rowi_w = $clog2(ROWS_PER_FRAME);
    localparam int c_ptr_w  = $clog2(ROW_DEPTH);
    localparam int c_cnt_w  = $clog2(ROW_DEPTH + 1);

    localparam logic [c_col_w-1:0]  c_last_col = c_col_w'(ROW_WORDS - 1);
    localparam logic [c_rowi_w-1:0] c_last_row = c_rowi_w'(ROWS_PER_FRAME - 1);
    localparam logic [c_cnt_w-1:0]  c_full     = c_cnt_w'(ROW_DEPTH);

    logic [c_row_w-1:0]    r_rows [ROW_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic [c_col_w-1:0]    r_col;
    logic [c_rowi_w-1:0]   r_row;

    logic [c_row_w-1:0]    w_head;
    logic [DATA_WIDTH-1:0] w_words [ROW_WORDS];
    logic                  w_push;
    logic                  w_beat;
    logic                  w_pop;
    logic                  w_col_end;

    // Handshake flags are derived from the registered occupancy only, so
    // row_ready has no combinational dependence on data_ready.
    assign row_ready  = (r_count != c_full);
    assign data_valid = (r_count != '0);
    assign w_push     = row_valid && row_ready;
    assign w_beat     = data_valid && data_ready;
    assign w_col_end  = (r_col == c_last_col);
    assign w_pop      = w_beat && w_col_end;

    // Split the head row into words; word 0 sits in the top slice.
    assign w_head = r_rows[r_rd_ptr];
    generate
        for (genvar k = 0; k < ROW_WORDS; k++) begin : g_unpack
            assign w_words[k] = w_head[(ROW_WORDS-k)*DATA_WIDTH-1 -: DATA_WIDTH];
        end
    endgenerate

    assign data_out  = w_words[r_col];
    assign col_index = r_col;
    assign row_index = r_row;
    assign last      = data_valid && w_col_end && (r_row == c_last_row);

    // Row storage: capture an accepted row at the write pointer; flush wipes all rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROW_DEPTH; i++) begin
                r_rows[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < ROW_DEPTH; i++) begin
                r_rows[i] <= '0;
            end
        end else if (w_push) begin
            r_rows[r_wr_ptr] <= row_in;
        end
    end

    // FIFO pointers, occupancy and the column/row position of the output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_col    <= '0;
            r_row    <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_col    <= '0;
            r_row    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (w_beat) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= (r_row == c_last_row) ? '0 : r_row + c_rowi_w'(1);
                end else begin
                    r_col <= r_col + c_col_w'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_layer_output_serializer
// Description : Scoreboard bench for conv_layer_output_serializer. Accepted
//               rows are expanded into expected words in a queue; a monitor
//               compares every presented word against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_layer_output_serializer;

    localparam int DW    = 32;
    localparam int RW    = 6;
    localparam int RPF   = 6;
    localparam int DEPTH = 2;
    localparam int ROW_W = RW * DW;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic [ROW_W-1:0] row_in;
    logic             row_valid;
    logic             row_ready;
    logic [DW-1:0]    data_out;
    logic             data_valid;
    logic             data_ready;
    logic [2:0]       col_index;
    logic [2:0]       row_index;
    logic             last;

    conv_layer_output_serializer #(
        .DATA_WIDTH     (DW),
        .ROW_WORDS      (RW),
        .ROWS_PER_FRAME (RPF),
        .ROW_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .row_in     (row_in),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .col_index  (col_index),
        .row_index  (row_index),
        .last       (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            col;
        int            row;
        logic          lst;
    } exp_t;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   enq_pos    = 0;   // position within the frame of the next enqueued word
    int   beats      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model + monitor: outputs are sampled mid-cycle, then the
    // model advances to the state expected after the coming rising edge.
    always @(negedge clk) begin
        int   pending;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            enq_pos = 0;
            check("rst_data_valid", data_valid, 0);
            check("rst_row_ready", row_ready, 1);
            check("rst_col", col_index, 0);
            check("rst_row", row_index, 0);
            check("rst_last", last, 0);
        end else begin
            pending = (q.size() + RW - 1) / RW;
            check("data_valid", data_valid, q.size() != 0);
            check("row_ready", row_ready, pending < DEPTH);
            if (q.size() != 0) begin
                check("data_out", data_out, q[0].data);
                check("col_index", col_index, q[0].col);
                check("row_index", row_index, q[0].row);
                check("last", last, q[0].lst);
            end else begin
                check("last_idle", last, 0);
            end
            if (clear) begin
                q.delete();
                enq_pos = 0;
            end else begin
                if (q.size() != 0 && data_ready) begin
                    void'(q.pop_front());
                    beats++;
                end
                if (row_valid && pending < DEPTH) begin
                    for (int k = 0; k < RW; k++) begin
                        e.data = row_in[(RW-k)*DW-1 -: DW];
                        e.col  = k;
                        e.row  = enq_pos / RW;
                        e.lst  = (enq_pos == RW*RPF - 1);
                        q.push_back(e);
                        enq_pos = (enq_pos + 1) % (RW*RPF);
                    end
                end
            end
        end
    end

    task automatic push_row(input logic [ROW_W-1:0] r);
        logic ok;
        ok = 1'b0;
        row_in    = r;
        row_valid = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (row_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        row_valid = 1'b0;
        check("push_accepted", ok, 1);
    endtask

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] r;
        for (int k = 0; k < RW; k++) r[k*DW +: DW] = $urandom;
        return r;
    endfunction

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", done, 1);
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        logic [ROW_W-1:0] r;
        logic             found;

        rst_n      = 1'b0;
        clear      = 1'b0;
        row_valid  = 1'b0;
        row_in     = '0;
        data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", data_out, 0);
        rst_n = 1'b1;

        // Single row of 1.0 .. 6.0
        data_ready = 1'b1;
        beats = 0;
        push_row({32'h3F800000, 32'h40000000, 32'h40400000,
                  32'h40800000, 32'h40A00000, 32'h40C00000});
        wait_drain();
        check("single_beats", beats, 6);
        do_clear();

        // Full frame, row r word k = r*10+k
        beats = 0;
        for (int rr = 0; rr < RPF; rr++) begin
            for (int k = 0; k < RW; k++) r[(RW-k)*DW-1 -: DW] = rr*10 + k;
            push_row(r);
        end
        wait_drain();
        check("frame_beats", beats, 36);
        check("frame_wrap_row", row_index, 0);
        do_clear();

        // Backpressure until the FIFO is full, then release
        data_ready = 1'b0;
        beats = 0;
        fork
            begin
                for (int i = 0; i < 3; i++) push_row(rand_row());
            end
            begin
                repeat (8) @(posedge clk);
                @(negedge clk);
                check("bp_ready_low", row_ready, 0);
                check("bp_hold_col", col_index, 0);
                @(posedge clk); #1;
                data_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_beats", beats, 18);
        do_clear();

        // Random stalls over two frames
        beats = 0;
        fork
            begin
                for (int i = 0; i < 2*RPF; i++) push_row(rand_row());
            end
            begin
                for (int t = 0; t < 3000 && beats < 72; t++) begin
                    @(posedge clk); #1;
                    data_ready = $urandom_range(0, 1);
                end
                data_ready = 1'b1;
            end
        join
        check("stall_beats", beats, 72);
        do_clear();

        // Flush after the third word of row 1 with another row queued
        data_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_row(rand_row());
        found = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (data_valid && row_index == 3'd1 && col_index == 3'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("flush_point_found", found, 1);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("flush_valid", data_valid, 0);
        check("flush_ready", row_ready, 1);
        check("flush_col", col_index, 0);
        check("flush_row", row_index, 0);
        @(posedge clk); #1;
        beats = 0;
        push_row(rand_row());
        wait_drain();
        check("post_flush_beats", beats, 6);

        // Asynchronous reset between clock edges while streaming
        @(posedge clk); #1;
        push_row(rand_row());
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", data_valid, 0);
        check("arst_ready", row_ready, 1);
        check("arst_col", col_index, 0);
        check("arst_row", row_index, 0);
        check("arst_last", last, 0);
        check("arst_data", data_out, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        beats = 0;
        push_row(rand_row());
        wait_drain();
        check("post_arst_beats", beats, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
